// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: debounced run/pause/clear control of a 4-digit BCD counter with leading-zero blanking
module bcd_count_ctrl #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_tick,
    input  logic        i_btn_run_n,
    input  logic        i_btn_clr_n,
    output logic [15:0] o_bcd,
    output logic [3:0]  o_blank,
    output logic [1:0]  o_state,
    output logic        o_wrap
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    state_t      state, state_nx;
    logic [1:0]  vld;
    logic [1:0]  btn_n;
    logic [1:0]  press;
    logic        run_p, clr_p;
    logic        inc;
    logic        carry;
    logic [15:0] bcd_inc;

    assign btn_n = {i_btn_clr_n, i_btn_run_n};
    assign run_p = press[0];
    assign clr_p = press[1];

    // marks when the synchronizer outputs carry real pin data rather than reset fill
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            vld <= 2'b00;
        else
            vld <= {vld[0], 1'b1};
    end

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic          s1, s2, deb, deb_d, armed;
        logic [CW-1:0] cnt;
        // two-flop synchronizer for the raw button
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                {s2, s1} <= 2'b11;
            else
                {s2, s1} <= {s1, btn_n[g]};
        end
        // accept a new level only after DEB_CYCLES consecutive differing samples
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                cnt <= '0;
                deb <= 1'b1;
            end else if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        // edge history plus arming: a button held through reset must be released before it counts
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                deb_d <= 1'b1;
                armed <= 1'b0;
            end else begin
                deb_d <= deb;
                armed <= armed | (vld[1] & s2 & deb);
            end
        end
        assign press[g] = armed & deb_d & ~deb;
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next state: clear beats run when both pulse together
    always_comb begin
        state_nx = clr_p ? IDLE : run_p ? (state == RUN ? PAUSE : RUN) : state;
    end

    // FSM outputs: count enable only while registered state is RUN
    always_comb begin
        inc     = (state == RUN) & i_tick & ~clr_p;
        o_state = state;
    end

    // ripple BCD increment; carry out of the top digit flags the 9999 rollover
    always_comb begin
        carry   = 1'b1;
        bcd_inc = o_bcd;
        for (int i = 0; i < 4; i++) begin
            bcd_inc[4*i +: 4] = carry ? (o_bcd[4*i +: 4] == 4'd9 ? 4'd0 : o_bcd[4*i +: 4] + 4'd1) : o_bcd[4*i +: 4];
            carry             = carry & (o_bcd[4*i +: 4] == 4'd9);
        end
    end

    // counter and wrap pulse; clear forces zero and suppresses any tick that cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_bcd  <= 16'h0000;
            o_wrap <= 1'b0;
        end else if (clr_p) begin
            o_bcd  <= 16'h0000;
            o_wrap <= 1'b0;
        end else begin
            o_bcd  <= inc ? bcd_inc : o_bcd;
            o_wrap <= inc & carry;
        end
    end

    // leading-zero suppression; the units digit is always shown
    always_comb begin
        o_blank[3] = o_bcd[15:12] == 4'd0;
        o_blank[2] = o_blank[3] & (o_bcd[11:8] == 4'd0);
        o_blank[1] = o_blank[2] & (o_bcd[7:4] == 4'd0);
        o_blank[0] = 1'b0;
    end
endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
Run/pause/clear controller for a 4-digit decimal counter shown on the board's 7-segment displays. It takes the one-cycle tick from const_div and two raw active-low push-buttons, and sequences a BCD counter through IDLE/RUN/PAUSE. It drives four BCD digits plus a leading-zero blank mask into four dec_7seg instances. It sits between const_div, the KEY inputs and the display decoders in the top-level demo.

Parameters:
DEB_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (20 ms at 50 MHz); counter width = ceil(log2(DEB_CYCLES+1))

Ports:
i_clk  input  1  system clock (MAX10_CLK1_50)
i_rst_n  input  1  asynchronous active-low reset
i_tick  input  1  one-cycle count enable from const_div
i_btn_run_n  input  1  raw run/pause button, active-low, asynchronous to i_clk
i_btn_clr_n  input  1  raw clear button, active-low, asynchronous to i_clk
o_bcd  output  16  digits {d3,d2,d1,d0}, 4 bits each, d0 = least significant
o_blank  output  4  per-digit blank mask, bit i blanks digit i
o_state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE
o_wrap  output  1  one-cycle pulse on 9999->0000 rollover

Behaviour:
- One clock domain: i_clk. Asynchronous active-low reset i_rst_n clears every flop immediately.
- Reset values:
  - o_bcd = 16'h0000, o_state = IDLE, o_wrap = 0, o_blank = 4'b1110.
  - Synchronizer flops and debounced levels reset to 1 (released); debounce counters reset to 0.
- Input conditioning, identical per button:
  - Two-flop synchronizer.
  - Debounce: counter clears whenever the synced value equals the debounced level, otherwise increments.
  - When the counter reaches DEB_CYCLES-1 with the value still differing, the debounced level takes the synced value and the counter clears.
  - Press pulse = one cycle on a debounced 1->0 transition. Release generates nothing.
  - Press-to-pulse latency: 2 sync cycles + DEB_CYCLES cycles.
- FSM, transitions on a press pulse only:
  - IDLE: run -> RUN.
  - RUN: run -> PAUSE; clr -> IDLE.
  - PAUSE: run -> RUN; clr -> IDLE.
  - Clr in IDLE: stays IDLE.
  - Run and clr pulses in the same cycle: clr wins.
- Counter:
  - Increments only when the current (registered) state is RUN and i_tick = 1. The result is visible on o_bcd the following edge.
  - BCD ripple: a digit at 9 goes to 0 and carries into the next digit.
  - 9999 + 1 -> 0000, with o_wrap = 1 for exactly that one cycle (registered on the same edge).
  - Any transition into IDLE (clr pulse) forces o_bcd = 0000 on that edge, overriding a simultaneous tick. No o_wrap is generated.
  - Run pulse together with i_tick while in RUN: the increment still happens and the state moves to PAUSE.
  - Run pulse together with i_tick while in PAUSE: no increment that cycle; counting resumes from the next tick.
  - i_tick while IDLE or PAUSE: ignored.
- o_blank is combinational from o_bcd (leading-zero suppression):
  - bit3 = (d3 == 0)
  - bit2 = bit3 & (d2 == 0)
  - bit1 = bit2 & (d1 == 0)
  - bit0 = 0, always
- Reset mid-count or mid-debounce: immediate return to reset values. A button held through reset release is treated as pressed only after it is released and pressed again.

Test Plan:
(Bench uses DEB_CYCLES = 4; i_tick pulsed every 3 cycles unless stated.)
- Reset -> o_bcd = 0000, o_state = 0, o_blank = 1110, o_wrap = 0. Ticks in IDLE -> o_bcd stays 0000.
- Run press held 8 cycles, then 12 ticks -> pulse 6 cycles after press, o_state = 1, o_bcd = 0012, o_blank = 1100. Second run press -> o_state = 2; further ticks leave 0012.
- Bounce: run_n toggled every 2 cycles for 20 cycles, then held low -> exactly one press pulse, state changes once.
- Preload by ticking to 9998 (force i_tick = 1 every cycle), 2 more ticks -> 9999, then 0000 with o_wrap high for one cycle; o_blank = 1110.
- In RUN at 0007, clr press whose pulse coincides with i_tick -> o_bcd = 0000, o_state = 0, no wrap. Same-cycle run + clr pulses from PAUSE -> IDLE.
- Assert i_rst_n = 0 mid-count at 0345 while a button is held low -> immediate 0000 / IDLE. After reset release the held button gives no pulse until released and re-pressed.
